tbuf_fill_ctrl: RTL
===================

TBUF_FILL_CTRL -- requirements
Module: tbuf_fill_ctrl

Interface
REQ-001 Parameter: WIDTH, 11, translation-buffer address width.
REQ-002 Parameter: STALL_MAX, 15, maximum consecutive ALLOC cycles without a free entry before the fill is dropped.
REQ-003 Ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- except  in  1  pipeline exception/flush.
- except_thread  in  1  thread being flushed.
- miss0_valid / miss1_valid  in  1  miss request from lookup port 0 / 1.
- miss0_addr / miss1_addr  in  WIDTH  missing address.
- miss0_thread / miss1_thread  in  1  requesting thread.
- miss0_ready / miss1_ready  out  1  request accepted this cycle.
- mem_req_valid  out  1  fill request to memory.
- mem_req_addr  out  WIDTH  fill address.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  fill response.
- mem_rsp_err  in  1  fill faulted (qualified by mem_rsp_valid).
- cam_new_en  out  1  allocate strobe to the buffer CAM.
- cam_new_addr  out  WIDTH  allocate address.
- cam_new_thread  out  1  allocate thread; also selects the CAM free report.
- cam_free  in  1  the CAM has a free entry for cam_new_thread.
- busy  out  1  state != IDLE.
- drop  out  1  one-cycle pulse when an accepted fill ends without allocation.

Function
REQ-004 The FSM SHALL have four states: IDLE, REQ, WAIT, ALLOC; only one fill is in flight at a time.
REQ-005 In IDLE with at least one valid miss, the controller SHALL grant one port: if only one port is valid, that port; if both are valid, the port != rr_last. miss*_ready SHALL be asserted combinationally in the same cycle.
REQ-006 On a grant, the controller SHALL capture addr/thread into cur_addr/cur_thread, set rr_last to the granted port, and go to REQ.
REQ-007 When both ports are valid with equal addr and thread, the controller SHALL assert both miss*_ready and service a single fill; rr_last SHALL still update to the port selected by REQ-005.
REQ-008 A candidate whose thread equals except_thread while except=1 SHALL NOT be granted in that cycle. The other port MAY be granted if it is eligible.
REQ-009 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL be cur_addr, held stable until mem_req_ready; on the handshake the FSM SHALL go to WAIT.
REQ-010 In REQ, an except matching cur_thread without a same-cycle handshake SHALL return the FSM to IDLE and pulse drop; no request is issued.
REQ-011 In REQ, an except matching cur_thread with a same-cycle handshake SHALL go to WAIT with the kill flag set.
REQ-012 In WAIT, a matching except SHALL set kill.
REQ-013 In WAIT, on mem_rsp_valid the FSM SHALL go to IDLE with a drop pulse if kill or mem_rsp_err is set; otherwise it SHALL go to ALLOC. kill SHALL clear on leaving WAIT.
REQ-014 In ALLOC, cam_new_thread/cam_new_addr SHALL be cur_thread/cur_addr. cam_new_en SHALL equal cam_free & ~(except & except_thread==cur_thread).
- If cam_new_en=1, the FSM SHALL go to IDLE.
- A matching except SHALL go to IDLE with a drop pulse.
- Otherwise the FSM SHALL remain in ALLOC and increment stall_cnt.
REQ-015 When stall_cnt reaches STALL_MAX with cam_free=0, the FSM SHALL go to IDLE with a drop pulse. stall_cnt SHALL clear on entry to ALLOC.
REQ-016 Outside ALLOC, cam_new_en SHALL be 0. Outside REQ, mem_req_valid SHALL be 0. Outside IDLE, miss*_ready SHALL be 0.
REQ-017 mem_rsp_valid in any state other than WAIT SHALL be ignored.
REQ-018 A fill's latency from grant to cam_new_en SHALL be a minimum of 3 cycles (REQ, WAIT with same-cycle ready/response, ALLOC).

Reset
REQ-019 While rst=1, the FSM SHALL go to IDLE, and rr_last=1 so that port 0 wins first, kill=0, stall_cnt=0, cur_addr=0 and cur_thread=0.
REQ-020 While rst=1, all outputs SHALL be 0.
REQ-021 rst SHALL override any in-flight fill. A response arriving after reset SHALL be ignored per REQ-017.

Verification
REQ-022 Single miss: miss0 addr=0x155 thread 0, ready/rsp immediate, cam_free=1 -> miss0_ready in cycle 0, mem_req_addr=0x155 in cycle 1, cam_new_en with addr 0x155 thread 0 in cycle 3.
REQ-023 Arbitration: both ports valid, different addrs, held for 2 fills -> port 0 granted first, then port 1. Equal addr/thread on both ports -> both readies asserted, exactly one mem request.
REQ-024 Flush in WAIT: thread 1 fill in flight, except with except_thread=1, then mem_rsp_valid -> no cam_new_en, drop pulse, IDLE. except_thread=0 -> normal allocate.
REQ-025 Full CAM: cam_free=0 for 15 cycles in ALLOC -> drop pulse, no cam_new_en. cam_free rising at cycle 5 -> cam_new_en at cycle 5.
REQ-026 Error response and reset: mem_rsp_err=1 -> drop, no allocate. rst asserted in WAIT -> all outputs 0 next cycle, and a later stray mem_rsp_valid is ignored.

Source files
------------

// File: rtl/tbuf_fill_ctrl.sv
// Translation-buffer fill controller.
// Arbitrates two lookup miss ports, issues one memory fill at a time,
// waits for the response and allocates the result into the buffer CAM.
// A fill is dropped when it is flushed, faults, or cannot find a free CAM entry
// within STALL_MAX cycles.
module tbuf_fill_ctrl #(
  parameter int WIDTH     = 11,
  parameter int STALL_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             except,
  input  logic             except_thread,
  input  logic             miss0_valid,
  input  logic [WIDTH-1:0] miss0_addr,
  input  logic             miss0_thread,
  output logic             miss0_ready,
  input  logic             miss1_valid,
  input  logic [WIDTH-1:0] miss1_addr,
  input  logic             miss1_thread,
  output logic             miss1_ready,
  output logic             mem_req_valid,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_rsp_valid,
  input  logic             mem_rsp_err,
  output logic             cam_new_en,
  output logic [WIDTH-1:0] cam_new_addr,
  output logic             cam_new_thread,
  input  logic             cam_free,
  output logic             busy,
  output logic             drop
);

  localparam int CW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ALLOC} state_t;

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             kill_q, kill_d;
  logic [CW-1:0]    stall_cnt_q, stall_cnt_d;
  logic [WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic             cur_thread_q, cur_thread_d;

  logic rdy0, rdy1, mreq, cen, drp;
  logic hit, elig0, elig1, same, gnt1;

  // Next-state and output decode; a flush only matters when its thread
  // matches the fill (or the candidate) it is compared against.
  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    kill_d       = kill_q;
    stall_cnt_d  = stall_cnt_q;
    cur_addr_d   = cur_addr_q;
    cur_thread_d = cur_thread_q;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    mreq = 1'b0;
    cen  = 1'b0;
    drp  = 1'b0;
    gnt1 = 1'b0;

    hit   = except & (except_thread == cur_thread_q);
    elig0 = miss0_valid & ~(except & (miss0_thread == except_thread));
    elig1 = miss1_valid & ~(except & (miss1_thread == except_thread));
    same  = (miss0_addr == miss1_addr) & (miss0_thread == miss1_thread);

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          // Round-robin only when both compete; identical requests share one fill.
          gnt1         = (elig0 & elig1) ? ~rr_last_q : elig1;
          rdy0         = elig0 & (~gnt1 | (elig1 & same));
          rdy1         = elig1 & (gnt1 | (elig0 & same));
          cur_addr_d   = gnt1 ? miss1_addr : miss0_addr;
          cur_thread_d = gnt1 ? miss1_thread : miss0_thread;
          rr_last_d    = gnt1;
          kill_d       = 1'b0;
          state_d      = REQ;
        end
      end
      REQ: begin
        mreq = 1'b1;
        if (mem_req_ready) begin
          // Request already left: remember the flush and discard the response.
          kill_d  = hit;
          state_d = WAIT;
        end else if (hit) begin
          drp     = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        kill_d = kill_q | hit;
        if (mem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q | hit | mem_rsp_err) begin
            drp     = 1'b1;
            state_d = IDLE;
          end else begin
            stall_cnt_d = '0;
            state_d     = ALLOC;
          end
        end
      end
      ALLOC: begin
        cen = cam_free & ~hit;
        if (cen) begin
          state_d = IDLE;
        end else if (hit) begin
          drp     = 1'b1;
          state_d = IDLE;
        end else if (stall_cnt_q == CW'(STALL_MAX - 1)) begin
          // This is the STALL_MAX-th cycle without a free entry.
          drp     = 1'b1;
          state_d = IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; rr_last resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_last_q    <= 1'b1;
      kill_q       <= 1'b0;
      stall_cnt_q  <= '0;
      cur_addr_q   <= '0;
      cur_thread_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      kill_q       <= kill_d;
      stall_cnt_q  <= stall_cnt_d;
      cur_addr_q   <= cur_addr_d;
      cur_thread_q <= cur_thread_d;
    end
  end

  // Outputs are forced low while reset is held, even before the state flops settle.
  assign miss0_ready    = rdy0 & ~rst;
  assign miss1_ready    = rdy1 & ~rst;
  assign mem_req_valid  = mreq & ~rst;
  assign mem_req_addr   = rst ? '0 : cur_addr_q;
  assign cam_new_en     = cen & ~rst;
  assign cam_new_addr   = rst ? '0 : cur_addr_q;
  assign cam_new_thread = cur_thread_q & ~rst;
  assign busy           = (state_q != IDLE) & ~rst;
  assign drop           = drp & ~rst;

endmodule
